// File: rtl/btb_update_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : btb_update_arbiter                                               |
// | Brief   : Two-source (Ex/Pd) FIFO arbiter feeding the single BTB write port|
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module btb_update_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        Clk,
  input  logic        Rest,
  input  logic        BtbStop,
  input  logic        BtbFlash,
  input  logic        PdValid,
  output logic        PdReady,
  input  logic [75:0] PdPayload,
  input  logic        ExValid,
  output logic        ExReady,
  input  logic [75:0] ExPayload,
  output logic        UpAble,
  output logic [1:0]  UpAbleBank,
  output logic [31:0] UpPc,
  output logic        UpCntAble,
  output logic [3:0]  UpCnt,
  output logic        BtbUpTypeAble,
  output logic [2:0]  BtbUpType,
  output logic        BtbUpTagetAble,
  output logic [31:0] BtbUpTaget,
  output logic        ArbBusy
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(DEPTH);
  localparam logic [c_ST_W-1:0]  c_ST_MAX = c_ST_W'(STARVE_LIMIT);

  logic [75:0]        r_pdMem [DEPTH];
  logic [75:0]        r_exMem [DEPTH];
  logic [c_PTR_W-1:0] r_pdWr, r_pdRd, r_exWr, r_exRd;
  logic [c_CNT_W-1:0] r_pdCount, r_exCount;
  logic [c_ST_W-1:0]  r_starve;

  logic        w_pdPush, w_exPush, w_pdGrant, w_exGrant;
  logic [75:0] w_head;

  // Ready is based on the registered count only, so a full FIFO never accepts.
  assign PdReady  = (r_pdCount != c_FULL);
  assign ExReady  = (r_exCount != c_FULL);
  assign w_pdPush = PdValid & PdReady & ~BtbFlash;
  assign w_exPush = ExValid & ExReady;

  assign w_exGrant = ~BtbStop & (r_exCount != '0) &
                     ((r_pdCount == '0) | (r_starve < c_ST_MAX));
  assign w_pdGrant = ~BtbStop & ~w_exGrant & (r_pdCount != '0) & ~BtbFlash;

  assign w_head = w_exGrant ? r_exMem[r_exRd] :
                  w_pdGrant ? r_pdMem[r_pdRd] : '0;

  assign ArbBusy = (r_pdCount != '0) | (r_exCount != '0) | UpAble;

  always_ff @(posedge Clk) begin
    if (w_pdPush) r_pdMem[r_pdWr] <= PdPayload;
    if (w_exPush) r_exMem[r_exWr] <= ExPayload;
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_pdWr    <= '0;
      r_pdRd    <= '0;
      r_pdCount <= '0;
    end else if (BtbFlash) begin
      r_pdWr    <= '0;
      r_pdRd    <= '0;
      r_pdCount <= '0;
    end else begin
      if (w_pdPush)  r_pdWr <= r_pdWr + c_PTR_W'(1);
      if (w_pdGrant) r_pdRd <= r_pdRd + c_PTR_W'(1);
      case ({w_pdPush, w_pdGrant})
        2'b10:   r_pdCount <= r_pdCount + c_CNT_W'(1);
        2'b01:   r_pdCount <= r_pdCount - c_CNT_W'(1);
        default: r_pdCount <= r_pdCount;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_exWr    <= '0;
      r_exRd    <= '0;
      r_exCount <= '0;
    end else begin
      if (w_exPush)  r_exWr <= r_exWr + c_PTR_W'(1);
      if (w_exGrant) r_exRd <= r_exRd + c_PTR_W'(1);
      case ({w_exPush, w_exGrant})
        2'b10:   r_exCount <= r_exCount + c_CNT_W'(1);
        2'b01:   r_exCount <= r_exCount - c_CNT_W'(1);
        default: r_exCount <= r_exCount;
      endcase
    end
  end

  // Starvation counter: only counts Ex wins while Pd work is actually waiting.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_starve <= '0;
    end else if (BtbFlash) begin
      r_starve <= '0;
    end else if (!BtbStop) begin
      if (w_pdGrant || (r_pdCount == '0))
        r_starve <= '0;
      else if (w_exGrant && (r_starve != c_ST_MAX))
        r_starve <= r_starve + c_ST_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      UpAble <= 1'b0;
      {UpPc, UpAbleBank, UpCntAble, UpCnt, BtbUpTypeAble, BtbUpType,
       BtbUpTagetAble, BtbUpTaget} <= '0;
    end else begin
      UpAble <= w_exGrant | w_pdGrant;
      {UpPc, UpAbleBank, UpCntAble, UpCnt, BtbUpTypeAble, BtbUpType,
       BtbUpTagetAble, BtbUpTaget} <= w_head;
    end
  end

endmodule
`default_nettype wire
